major_state_seq: RTL and testbench

- Major-state sequencer for the PDP-8/e core. Generates the 5-bit `state` that drives the memory address/data stage, the AC/ALU and the PC logic.
- Sequences fetch (F), defer (D), execute (E), front-panel/halt (H) and EAE mode-B double-word (EAE) cycles.
- Inserts interrupt cycles and latches front-panel requests into the `addr_loadd`/`depd`/`examd` flags consumed downstream.
- State encodings are the team's shared state constants (F0,FW,F1,F2,F3,D0,DW,D1,D2,D3,E0,EW,E1,E2,E3,H0,HW,H1,H2,H3,EAE1..EAE5).

---
 rtl/major_state_seq_if.sv | 35 +++
 rtl/major_state_seq.sv | 169 ++++++++++++++++
 tb/tb_major_state_seq.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/major_state_seq_if.sv
// Bundles the sequencer's control inputs and major-state outputs.
// The sequencer is the slave; the core/panel side is the master.
interface major_state_seq_if;
    logic [0:11] instruction;
    logic        eae_mode_b;
    logic        int_req;
    logic        int_ena;
    logic        int_inhibit;
    logic        sw_halt;
    logic        sw_sstep;
    logic        pb_addr_load;
    logic        pb_dep;
    logic        pb_exam;
    logic        pb_cont;
    logic        pb_start;
    logic [4:0]  state;
    logic        run;
    logic        int_in_prog;
    logic        addr_loadd;
    logic        depd;
    logic        examd;
    logic        clear_all;

    modport master (
        output instruction, eae_mode_b, int_req, int_ena, int_inhibit,
               sw_halt, sw_sstep, pb_addr_load, pb_dep, pb_exam, pb_cont, pb_start,
        input  state, run, int_in_prog, addr_loadd, depd, examd, clear_all
    );

    modport slave (
        input  instruction, eae_mode_b, int_req, int_ena, int_inhibit,
               sw_halt, sw_sstep, pb_addr_load, pb_dep, pb_exam, pb_cont, pb_start,
        output state, run, int_in_prog, addr_loadd, depd, examd, clear_all
    );
endinterface

// File: rtl/major_state_seq.sv
// PDP-8/e major-state sequencer: fetch/defer/execute/EAE/halt cycles,
// interrupt insertion and front-panel operation latching.
module major_state_seq #(
    parameter logic [0:11] HLT_CODE = 12'o7402
) (
    input  logic             clk,
    input  logic             reset,
    major_state_seq_if.slave bus
);

    typedef enum logic [4:0] {
        F0   = 5'd0,  FW   = 5'd1,  F1   = 5'd2,  F2   = 5'd3,  F3   = 5'd4,
        D0   = 5'd5,  DW   = 5'd6,  D1   = 5'd7,  D2   = 5'd8,  D3   = 5'd9,
        E0   = 5'd10, EW   = 5'd11, E1   = 5'd12, E2   = 5'd13, E3   = 5'd14,
        H0   = 5'd15, HW   = 5'd16, H1   = 5'd17, H2   = 5'd18, H3   = 5'd19,
        EAE1 = 5'd20, EAE2 = 5'd21, EAE3 = 5'd22, EAE4 = 5'd23, EAE5 = 5'd24
    } state_t;

    state_t     r_state, w_state;
    logic       r_run, w_run;
    logic       r_iip, w_iip;
    logic       r_addr_loadd, w_addr_loadd;
    logic       r_depd, w_depd;
    logic       r_examd, w_examd;
    logic       r_clear_all, w_clear_all;

    logic [2:0] w_op;
    logic       w_ind;
    logic       w_hlt;
    logic       w_eae;
    logic       w_stop;
    logic       w_irq;
    logic       w_bnd;
    logic       w_int_blk;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= H0;
            r_run        <= 1'b0;
            r_iip        <= 1'b0;
            r_addr_loadd <= 1'b0;
            r_depd       <= 1'b0;
            r_examd      <= 1'b0;
            r_clear_all  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_run        <= w_run;
            r_iip        <= w_iip;
            r_addr_loadd <= w_addr_loadd;
            r_depd       <= w_depd;
            r_examd      <= w_examd;
            r_clear_all  <= w_clear_all;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_run        = r_run;
        w_iip        = r_iip;
        w_addr_loadd = r_addr_loadd;
        w_depd       = r_depd;
        w_examd      = r_examd;
        w_clear_all  = 1'b0;
        w_bnd        = 1'b0;
        w_int_blk    = 1'b0;

        w_op   = bus.instruction[0:2];
        w_ind  = bus.instruction[3];
        w_hlt  = (bus.instruction[0:3] == HLT_CODE[0:3]) &&
                 (bus.instruction[10]  == HLT_CODE[10])  &&
                 (bus.instruction[11]  == HLT_CODE[11]);
        w_eae  = bus.eae_mode_b &&
                 (((bus.instruction & 12'b111100101111) == 12'o7443) ||
                  ((bus.instruction & 12'b111100101111) == 12'o7445));
        w_stop = !r_run || bus.sw_halt || bus.sw_sstep || w_hlt;
        w_irq  = bus.int_req && bus.int_ena && !bus.int_inhibit;

        case (r_state)
            F0:   w_state = FW;
            FW:   w_state = F1;
            F1:   w_state = F2;
            F2:   w_state = F3;
            F3: begin
                if (w_op <= 3'd5 && w_ind) w_state = D0;
                else if (w_op <= 3'd4)     w_state = E0;
                else if (w_op == 3'd5)     w_bnd   = 1'b1;
                else if (w_eae)            w_state = EAE1;
                else                       w_bnd   = 1'b1;
            end
            D0:   w_state = DW;
            DW:   w_state = D1;
            D1:   w_state = D2;
            D2:   w_state = D3;
            D3: begin
                if (w_op <= 3'd4) w_state = E0;
                else              w_bnd   = 1'b1;
            end
            E0:   w_state = EW;
            EW:   w_state = E1;
            E1:   w_state = E2;
            E2:   w_state = E3;
            E3: begin
                // an interrupt cycle ends here; it must not chain straight into another
                w_iip     = 1'b0;
                w_int_blk = r_iip;
                w_bnd     = 1'b1;
            end
            EAE1: w_state = EAE2;
            EAE2: w_state = EAE3;
            EAE3: w_state = EAE4;
            EAE4: w_state = EAE5;
            EAE5: w_bnd   = 1'b1;
            H0: begin
                if (!r_run) begin
                    if (bus.pb_start) begin
                        w_run       = 1'b1;
                        w_iip       = 1'b0;
                        w_clear_all = 1'b1;
                        w_state     = HW;
                    end else if (bus.pb_cont) begin
                        w_run   = 1'b1;
                        w_state = HW;
                    end else if (bus.pb_addr_load) begin
                        w_addr_loadd = 1'b1;
                        w_state      = HW;
                    end else if (bus.pb_dep) begin
                        w_depd  = 1'b1;
                        w_state = HW;
                    end else if (bus.pb_exam) begin
                        w_examd = 1'b1;
                        w_state = HW;
                    end
                end
            end
            HW:   w_state = H1;
            H1:   w_state = H2;
            H2:   w_state = H3;
            H3: begin
                w_addr_loadd = 1'b0;
                w_depd       = 1'b0;
                w_examd      = 1'b0;
                if (r_run) w_state = F0;
                else       w_state = H0;
            end
            default: w_state = H0;
        endcase

        if (w_bnd) begin
            if (w_stop) begin
                w_state = H0;
                w_run   = 1'b0;
            end else if (w_irq && !w_int_blk) begin
                w_state = E0;
                w_iip   = 1'b1;
            end else begin
                w_state = F0;
            end
        end
    end

    assign bus.state       = r_state;
    assign bus.run         = r_run;
    assign bus.int_in_prog = r_iip;
    assign bus.addr_loadd  = r_addr_loadd;
    assign bus.depd        = r_depd;
    assign bus.examd       = r_examd;
    assign bus.clear_all   = r_clear_all;

endmodule

// File: tb/tb_major_state_seq.sv
// Bench for major_state_seq: directed panel/instruction scenarios, then random
// stimulus, all checked every cycle against a segment-queue model of the sequencer.
module tb_major_state_seq;
    localparam int F0 = 0,  FW = 1,  F1 = 2,  F2 = 3,  F3 = 4;
    localparam int D0 = 5,  DW = 6,  D1 = 7,  D2 = 8,  D3 = 9;
    localparam int E0 = 10, EW = 11, E1 = 12, E2 = 13, E3 = 14;
    localparam int H0 = 15, HW = 16, H1 = 17, H2 = 18, H3 = 19;
    localparam int EAE1 = 20;

    logic clk = 1'b0;
    logic reset;
    major_state_seq_if bus();
    major_state_seq dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: current state plus a queue of the states left in the current cycle group.
    typedef enum int {K_IDLE, K_FETCH, K_DEFER, K_EXEC, K_EAE, K_PANEL} kind_t;
    int    m_st;
    int    m_q[$];
    kind_t m_kind;
    bit    m_run, m_iip, m_al, m_dp, m_ex, m_clr;

    function automatic void enter(kind_t k);
        int base;
        int len;
        len = 5;
        case (k)
            K_FETCH: base = F0;
            K_DEFER: base = D0;
            K_EXEC:  base = E0;
            K_EAE:   base = EAE1;
            default: begin base = HW; len = 4; end
        endcase
        m_q.delete();
        for (int i = 0; i < len; i++) m_q.push_back(base + i);
        m_kind = k;
        m_st   = m_q.pop_front();
    endfunction

    function automatic void boundary(bit blk);
        int ins;
        bit hlt;
        ins = int'(bus.instruction);
        hlt = ((ins >> 8) == 'hF) && ((ins & 2) != 0) && ((ins & 1) == 0);
        if (!m_run || bus.sw_halt || bus.sw_sstep || hlt) begin
            m_run = 0; m_st = H0; m_kind = K_IDLE; m_q.delete();
        end else if (bus.int_req && bus.int_ena && !bus.int_inhibit && !blk) begin
            m_iip = 1; enter(K_EXEC);
        end else begin
            enter(K_FETCH);
        end
    endfunction

    always @(posedge clk) begin : model
        int ins;
        int op;
        bit ind;
        bit eae;
        bit blk;
        ins = int'(bus.instruction);
        op  = ins >> 9;
        ind = ((ins >> 8) & 1) != 0;
        eae = bus.eae_mode_b && (((ins & 'o7457) == 'o7443) || ((ins & 'o7457) == 'o7445));
        m_clr = 0;
        if (!reset) begin
            m_q.delete(); m_st = H0; m_kind = K_IDLE;
            m_run = 0; m_iip = 0; m_al = 0; m_dp = 0; m_ex = 0;
        end else if (m_q.size() != 0) begin
            m_st = m_q.pop_front();
        end else begin
            case (m_kind)
                K_IDLE: if (!m_run) begin
                    if (bus.pb_start)          begin m_run = 1; m_iip = 0; m_clr = 1; enter(K_PANEL); end
                    else if (bus.pb_cont)      begin m_run = 1; enter(K_PANEL); end
                    else if (bus.pb_addr_load) begin m_al = 1; enter(K_PANEL); end
                    else if (bus.pb_dep)       begin m_dp = 1; enter(K_PANEL); end
                    else if (bus.pb_exam)      begin m_ex = 1; enter(K_PANEL); end
                end
                K_FETCH: begin
                    if (op <= 5 && ind) enter(K_DEFER);
                    else if (op <= 4)   enter(K_EXEC);
                    else if (op == 5)   boundary(0);
                    else if (eae)       enter(K_EAE);
                    else                boundary(0);
                end
                K_DEFER: if (op <= 4) enter(K_EXEC); else boundary(0);
                K_EXEC: begin blk = m_iip; m_iip = 0; boundary(blk); end
                K_EAE:  boundary(0);
                default: begin
                    m_al = 0; m_dp = 0; m_ex = 0;
                    if (m_run) enter(K_FETCH);
                    else begin m_st = H0; m_kind = K_IDLE; end
                end
            endcase
        end
    end

    task automatic step();
        logic [10:0] got;
        logic [10:0] want;
        @(negedge clk);
        got  = {bus.state, bus.run, bus.int_in_prog, bus.addr_loadd, bus.depd, bus.examd, bus.clear_all};
        want = {5'(m_st), m_run, m_iip, m_al, m_dp, m_ex, m_clr};
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL model_cmp @%0t: got st=%0d run,iip,al,dp,ex,clr=%b want st=%0d %b",
                     $time, got[10:6], got[5:0], want[10:6], want[5:0]);
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic wait_state(input string nm, input int s, input int max);
        int n;
        n = 0;
        while (bus.state !== 5'(s) && n < max) begin step(); n++; end
        lit(nm, 32'(bus.state), 32'(s));
    endtask

    task automatic clr_pulses();
        bus.pb_start = 0; bus.pb_cont = 0; bus.pb_addr_load = 0; bus.pb_dep = 0; bus.pb_exam = 0;
    endtask

    logic [11:0] tbl [14] = '{12'o7000, 12'o1410, 12'o5200, 12'o5600, 12'o7402, 12'o7443, 12'o7445,
                              12'o7447, 12'o3020, 12'o2410, 12'o6001, 12'o7401, 12'o4100, 12'o0300};
    int seq_exp [10] = '{HW, H1, H2, H3, F0, FW, F1, F2, F3, F0};

    initial begin
        int clr_cnt;
        int n;
        reset = 0;
        bus.instruction = 12'o7000;
        bus.eae_mode_b = 0; bus.int_req = 0; bus.int_ena = 0; bus.int_inhibit = 0;
        bus.sw_halt = 0; bus.sw_sstep = 0;
        clr_pulses();
        repeat (3) step();
        lit("reset_state", 32'(bus.state), H0);
        lit("reset_run", 32'(bus.run), 0);
        lit("reset_clear_all", 32'(bus.clear_all), 0);
        reset = 1;

        // START with NOP: panel sequence then free-running fetches
        bus.pb_start = 1; step(); clr_pulses();
        clr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            lit("start_seq", 32'(bus.state), 32'(seq_exp[i]));
            clr_cnt += int'(bus.clear_all);
            step();
        end
        lit("clear_all_pulses", 32'(clr_cnt), 1);
        lit("start_run", 32'(bus.run), 1);

        // TAD I 10 takes fetch+defer+execute = 15 cycles
        bus.instruction = 12'o1410;
        wait_state("wait_f0_tad", F0, 40);
        n = 0;
        do begin step(); n++; end while (bus.state !== 5'(F0) && n < 40);
        lit("tad_i_cycles", 32'(n), 15);

        bus.instruction = 12'o5200;
        wait_state("wait_f3_jmp", F3, 40);
        step(); lit("jmp_direct_next", 32'(bus.state), F0);
        bus.instruction = 12'o5600;
        wait_state("wait_d3_jmpi", D3, 40);
        step(); lit("jmp_ind_next", 32'(bus.state), F0);

        // interrupt at end of TAD, not retaken from the interrupt cycle's E3
        bus.instruction = 12'o1410;
        bus.int_req = 1; bus.int_ena = 1; bus.int_inhibit = 0;
        wait_state("wait_e3_tad", E3, 40);
        step();
        lit("int_state", 32'(bus.state), E0);
        lit("int_iip_set", 32'(bus.int_in_prog), 1);
        wait_state("wait_e3_int", E3, 10);
        step();
        lit("int_end_state", 32'(bus.state), F0);
        lit("int_iip_clr", 32'(bus.int_in_prog), 0);
        bus.int_inhibit = 1;
        wait_state("wait_e3_inh", E3, 40);
        step(); lit("inhibit_next", 32'(bus.state), F0);
        bus.int_req = 0; bus.int_inhibit = 0;

        // HLT instruction stops the machine
        bus.instruction = 12'o7402;
        wait_state("wait_h0_hlt", H0, 40);
        lit("hlt_run", 32'(bus.run), 0);

        // DEP and EXAM together: only DEP latched
        bus.pb_dep = 1; bus.pb_exam = 1; step(); clr_pulses();
        for (int i = 0; i < 4; i++) begin
            lit("dep_state", 32'(bus.state), 32'(HW + i));
            lit("dep_flag", 32'(bus.depd), 1);
            lit("exam_dropped", 32'(bus.examd), 0);
            step();
        end
        lit("dep_back_h0", 32'(bus.state), H0);
        lit("dep_cleared", 32'(bus.depd), 0);
        bus.pb_addr_load = 1; step(); clr_pulses();
        for (int i = 0; i < 4; i++) begin
            lit("al_flag", 32'(bus.addr_loadd), 1);
            step();
        end
        lit("al_back_h0", 32'(bus.state), H0);
        lit("al_cleared", 32'(bus.addr_loadd), 0);

        // single step: one NOP per CONT
        bus.sw_sstep = 1; bus.instruction = 12'o7000;
        bus.pb_cont = 1; step(); clr_pulses();
        lit("sstep_run", 32'(bus.run), 1);
        repeat (9) step();
        lit("sstep_h0", 32'(bus.state), H0);
        lit("sstep_stopped", 32'(bus.run), 0);

        // reset mid-execute
        bus.sw_sstep = 0; bus.instruction = 12'o1000;
        bus.pb_cont = 1; step(); clr_pulses();
        wait_state("wait_ew", EW, 30);
        reset = 0; step();
        lit("rst_ew_state", 32'(bus.state), H0);
        lit("rst_ew_run", 32'(bus.run), 0);
        reset = 1;

        for (int c = 0; c < 4000; c++) begin
            clr_pulses();
            reset = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 5) == 0) begin
                bus.pb_start     = ($urandom_range(0, 3) == 0);
                bus.pb_cont      = ($urandom_range(0, 1) == 0);
                bus.pb_addr_load = ($urandom_range(0, 2) == 0);
                bus.pb_dep       = ($urandom_range(0, 2) == 0);
                bus.pb_exam      = ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 5) == 0)
                bus.instruction = ($urandom_range(0, 3) == 0) ? 12'($urandom) : tbl[$urandom_range(0, 13)];
            if ($urandom_range(0, 15) == 0) bus.eae_mode_b = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 7) == 0) begin
                bus.int_req     = ($urandom_range(0, 1) == 0);
                bus.int_ena     = ($urandom_range(0, 2) != 0);
                bus.int_inhibit = ($urandom_range(0, 3) == 0);
            end
            bus.sw_halt  = ($urandom_range(0, 59) == 0);
            bus.sw_sstep = ($urandom_range(0, 59) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
